// File: rtl/p12_loader_pkg.sv
// Shared definitions for the byte-stream memory loader: opcodes, FSM states and sizing helper.
package p12_loader_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_READ     = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWrite,
    StRdSend
  } state_e;

  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Host byte streams (rx/tx valid-ready) plus the memory write/read port, as seen by the loader.
interface mem_loader_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_SIZE = 10
);

  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [ADDR_SIZE-1:0] mem_wa;
  logic [WIDTH-1:0]     mem_din;
  logic                 mem_wen;
  logic [ADDR_SIZE-1:0] mem_ra;
  logic [WIDTH-1:0]     mem_dout;

  // Loader side.
  modport master (
    input  rx_data, rx_valid, tx_ready, mem_dout,
    output rx_ready, tx_data, tx_valid, mem_wa, mem_din, mem_wen, mem_ra
  );

  // Host and memory side.
  modport slave (
    output rx_data, rx_valid, tx_ready, mem_dout,
    input  rx_ready, tx_data, tx_valid, mem_wa, mem_din, mem_wen, mem_ra
  );

endinterface

// File: rtl/mem_loader.sv
// Command-driven loader: SET_ADDR / WRITE / READ over a byte stream, driving a single-port memory.
module mem_loader
  import p12_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_loader_if.master bus,
  output logic         busy,
  output logic         err
);

  localparam int unsigned WB   = WIDTH / 8;
  localparam int unsigned AB   = bytes_for(ADDR_SIZE);
  localparam int unsigned TW   = AB * 8;
  localparam int unsigned MaxB = (AB > WB) ? AB : WB;
  localparam int unsigned CntW = (MaxB > 1) ? $clog2(MaxB) : 1;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [TW-1:0]        tmp_q, tmp_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 rx_fire, tx_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      shift_q <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode the registered state, so they are glitch-free and drop on reset.
  always_comb begin
    bus.rx_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StData);
    bus.tx_valid = (state_q == StRdSend);
    bus.tx_data  = shift_q[WIDTH-1 -: 8];
    bus.mem_wen  = (state_q == StWrite);
    bus.mem_wa   = addr_q;
    bus.mem_ra   = addr_q;
    bus.mem_din  = shift_q;
    busy         = (state_q != StIdle);
    err          = err_q;
  end

  always_comb begin
    rx_fire = bus.rx_valid && bus.rx_ready;
    tx_fire = bus.tx_valid && bus.tx_ready;
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    tmp_d   = tmp_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_fire) begin
          case (bus.rx_data)
            OP_SET_ADDR: begin
              state_d = StAddr;
              cnt_d   = '0;
            end
            OP_WRITE: begin
              state_d = StData;
              cnt_d   = '0;
            end
            OP_READ: begin
              shift_d = bus.mem_dout;
              cnt_d   = '0;
              state_d = StRdSend;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      StAddr: begin
        if (rx_fire) begin
          tmp_d = (tmp_q << 8) | TW'(bus.rx_data);
          if (cnt_q == CntW'(AB - 1)) begin
            // High bits beyond the address width are silently dropped.
            addr_d  = tmp_d[ADDR_SIZE-1:0];
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StData: begin
        if (rx_fire) begin
          shift_d = (shift_q << 8) | WIDTH'(bus.rx_data);
          if (cnt_q == CntW'(WB - 1)) begin
            cnt_d   = '0;
            state_d = StWrite;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StWrite: begin
        addr_d  = addr_q + ADDR_SIZE'(1);
        state_d = StIdle;
      end

      StRdSend: begin
        if (tx_fire) begin
          shift_d = shift_q << 8;
          if (cnt_q == CntW'(WB - 1)) begin
            addr_d  = addr_q + ADDR_SIZE'(1);
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader (WIDTH=16, ADDR_SIZE=10) with a behavioural async-read memory.
module tb_mem_loader;

  typedef enum int {VSet, VWrite, VRead, VBad} vkind_e;

  typedef struct {
    vkind_e      kind;
    logic [23:0] cmd;       // bytes sent MSB first
    int          nb;
    logic [9:0]  exp_addr;  // address after the command
    logic [9:0]  exp_wa;
    logic [15:0] exp_word;  // written word or read-back pair
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic busy, err;
  logic mem_clear;
  int   wr_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [15:0] mem [0:1023];
  vec_t vecs [13];

  mem_loader_if #(.WIDTH(16), .ADDR_SIZE(10)) bus ();

  mem_loader #(.WIDTH(16), .ADDR_SIZE(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_ra];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (bus.mem_wen) begin
      mem[bus.mem_wa] <= bus.mem_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("rx_ready_for_%02h", b), 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string name);
    int n;
    n = 0;
    bus.tx_ready = 1'b1;
    while (!bus.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(bus.tx_valid), 32'd1);
    chk(name, 32'(bus.tx_data), 32'(exp));
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    w0;
    string p;
    w0 = wr_cnt;
    p  = $sformatf("vec%0d", idx);
    for (int i = 0; i < v.nb; i++) send_byte(v.cmd[23 - 8 * i -: 8]);
    case (v.kind)
      VWrite: begin
        chk({p, "_wen"}, 32'(bus.mem_wen), 32'd1);
        chk({p, "_wa"}, 32'(bus.mem_wa), 32'(v.exp_wa));
        chk({p, "_din"}, 32'(bus.mem_din), 32'(v.exp_word));
        @(negedge clk);
        chk({p, "_wen_drop"}, 32'(bus.mem_wen), 32'd0);
        chk({p, "_nwrites"}, 32'(wr_cnt - w0), 32'd1);
      end
      VRead: begin
        recv_byte(v.exp_word[15:8], {p, "_tx0"});
        recv_byte(v.exp_word[7:0], {p, "_tx1"});
        chk({p, "_tx_idle"}, 32'(bus.tx_valid), 32'd0);
      end
      VBad: begin
        chk({p, "_err"}, 32'(err), 32'd1);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_wen"}, 32'(bus.mem_wen), 32'd0);
        @(negedge clk);
        chk({p, "_err_drop"}, 32'(err), 32'd0);
        chk({p, "_nwrites"}, 32'(wr_cnt - w0), 32'd0);
      end
      default: chk({p, "_busy"}, 32'(busy), 32'd0);
    endcase
    chk({p, "_addr"}, 32'(bus.mem_ra), 32'(v.exp_addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    vecs[0]  = '{VRead,  24'h030000, 1, 10'h001, 10'h000, 16'h0000};
    vecs[1]  = '{VSet,   24'h010005, 3, 10'h005, 10'h000, 16'h0000};
    vecs[2]  = '{VWrite, 24'h021234, 3, 10'h006, 10'h005, 16'h1234};
    vecs[3]  = '{VWrite, 24'h02ABCD, 3, 10'h007, 10'h006, 16'hABCD};
    vecs[4]  = '{VSet,   24'h010005, 3, 10'h005, 10'h000, 16'h0000};
    vecs[5]  = '{VRead,  24'h030000, 1, 10'h006, 10'h000, 16'h1234};
    vecs[6]  = '{VRead,  24'h030000, 1, 10'h007, 10'h000, 16'hABCD};
    vecs[7]  = '{VSet,   24'h01FFFF, 3, 10'h3FF, 10'h000, 16'h0000};
    vecs[8]  = '{VWrite, 24'h020011, 3, 10'h000, 10'h3FF, 16'h0011};
    vecs[9]  = '{VWrite, 24'h020022, 3, 10'h001, 10'h000, 16'h0022};
    vecs[10] = '{VBad,   24'h550000, 1, 10'h001, 10'h000, 16'h0000};
    vecs[11] = '{VSet,   24'h010000, 3, 10'h000, 10'h000, 16'h0000};
    vecs[12] = '{VRead,  24'h030000, 1, 10'h001, 10'h000, 16'h0022};

    reset_n      = 1'b0;
    mem_clear    = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(bus.mem_ra), 32'd0);
    mem_clear = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Backpressure: outputs must hold while the consumer stalls.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_valid_%0d", i), 32'(bus.tx_valid), 32'd1);
      chk($sformatf("bp_data_%0d", i), 32'(bus.tx_data), 32'h12);
      chk($sformatf("bp_rx_ready_%0d", i), 32'(bus.rx_ready), 32'd0);
      @(negedge clk);
    end
    recv_byte(8'h12, "bp_tx0");
    recv_byte(8'h34, "bp_tx1");
    chk("bp_addr", 32'(bus.mem_ra), 32'h006);

    // Reset after one data byte of a WRITE: partial word is dropped.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h08);
    w0 = wr_cnt;
    send_byte(8'h02); send_byte(8'h12);
    chk("mid_wr_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_wr_rst_busy", 32'(busy), 32'd0);
    chk("mid_wr_rst_addr", 32'(bus.mem_ra), 32'd0);
    chk("mid_wr_rst_wen", 32'(bus.mem_wen), 32'd0);
    chk("mid_wr_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_wr_nwrites", 32'(wr_cnt - w0), 32'd0);
    chk("mid_wr_mem8", 32'(mem[8]), 32'd0);

    // Reset during a stalled READ: tx_valid must fall at once.
    send_byte(8'h03);
    chk("mid_rd_valid", 32'(bus.tx_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rd_rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_rd_rst_data", 32'(bus.tx_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rd_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
